// File: rtl/seg7_scan_ctrl.sv
// Four-digit 7-segment scan controller: double-buffered digit codes, blanked slot switches, outputs registered-only (no comb input path).
// Commit latency is up to one frame (4*DIV cycles); writes are refused (wr_ready low) while a commit waits for the frame boundary.
module seg7_scan_ctrl #(
    parameter int DIV   = 1000,
    parameter int BLANK = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic [1:0] wr_addr,
    input  logic [3:0] wr_data,
    output logic       wr_ready,
    input  logic       commit,
    output logic       commit_pending,
    output logic [3:0] digit,
    output logic [3:0] digit_en,
    output logic       frame_start
);
    localparam int CW = $clog2(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic [3:0][3:0] shadow_q, shadow_d;
    logic [3:0][3:0] active_q, active_d;
    logic            pending_q, pending_d;

    logic slot_end, fb, wr_fire, commit_eff;

    always_comb begin
        slot_end   = (cnt_q == LAST);
        fb         = slot_end && (idx_q == 2'd3);
        wr_fire    = wr_valid && !pending_q;
        commit_eff = commit || pending_q;

        cnt_d      = slot_end ? '0 : cnt_q + CW'(1);
        idx_d      = slot_end ? idx_q + 2'd1 : idx_q;

        shadow_d   = shadow_q;
        if (wr_fire) begin
            shadow_d[wr_addr] = wr_data;
        end

        // Same-cycle write is folded into the copy so a write+commit pair lands together.
        active_d  = active_q;
        pending_d = pending_q;
        if (commit_eff) begin
            if (fb) begin
                active_d  = shadow_d;
                pending_d = 1'b0;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
        end
    end

    assign digit          = active_q[idx_q];
    assign wr_ready       = !pending_q;
    assign commit_pending = pending_q;
    assign frame_start    = (cnt_q == '0) && (idx_q == 2'd0);

    generate
        if (BLANK == 0) begin : g_no_blank
            assign digit_en = 4'b0001 << idx_q;
        end else begin : g_blank
            localparam logic [CW-1:0] BL = CW'(BLANK);
            assign digit_en = (cnt_q >= BL) ? (4'b0001 << idx_q) : 4'b0000;
        end
    endgenerate
endmodule
